alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Upstream command stage for the 16-bit ALU (ALU_16bit). It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time on registered operand/control lines, captures the ALU's combinational Result/Cout, and returns them on a valid/ready response port. It keeps an accumulator so chained operations can reuse the previous result as operand A.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
WIDTH, 16, operand/result width; must match ALU

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_a  in  WIDTH  operand A (ignored if cmd_use_acc)
cmd_b  in  WIDTH  operand B
cmd_cin  in  1  carry/borrow in
cmd_op  in  3  ALU control code
cmd_use_acc  in  1  take A from accumulator
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_cin  out  1  to ALU Cin
alu_ctrl  out  3  to ALU Control
alu_result  in  WIDTH  from ALU Result
alu_cout  in  1  from ALU Cout
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result
rsp_cout  out  1  captured carry
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: FIFO empty; state IDLE; alu_a, alu_b, alu_cin, alu_ctrl = 0; rsp_valid = 0; rsp_result, rsp_cout = 0; acc = 0; busy = 0.
- A reset asserted mid-operation discards all queued, in-flight and pending responses.
- Push: on cmd_valid && cmd_ready. cmd_ready = !fifo_full, a combinational function of FIFO occupancy only. There is no FIFO bypass.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head. Load alu_* from it; alu_a = acc if use_acc else cmd_a. Go to EXEC.
  - EXEC: capture alu_result/alu_cout into rsp_result/rsp_cout and acc. Set rsp_valid. Go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid. If the FIFO is non-empty at that same edge, pop and go to EXEC (skip IDLE); else go to IDLE.
- Latency: a command accepted at edge E0 into an empty, idle unit pops at E0+1, and rsp_valid is high after E0+2.
- Throughput: one result per 2 cycles with rsp_ready held high.
- use_acc reads the acc value updated by the previous capture. Chaining back-to-back therefore works without stalls.
- Simultaneous push and pop are allowed at any non-full occupancy; count is unchanged.
- At full, cmd_ready is low even if a pop occurs on the same edge (no same-cycle refill).
- alu_* remain stable from pop until the next pop.
- FIFO pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- Arithmetic is done entirely by the ALU. This block never modifies values.

Optional Feature:
ALU_FLAGS_EN
- Defined: adds outputs rsp_zero (rsp_result == 0) and rsp_neg (rsp_result[WIDTH-1]). Both are registered at EXEC capture together with rsp_result and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD=000, OP_SUB=001, OP_OR=010, OP_AND=011, OP_SHL=100, OP_SHR=101, OP_ROL=110, OP_ROR=111.
  - FSM state encoding IDLE/EXEC/RESP.
  - Packed command word layout: {use_acc, op, cin, b, a}.
- Sub-module: alu_cmd_fifo (synchronous FIFO, DEPTH x command word, full/empty outputs).

Test Plan:
- Single add: cmd A=0x0002, B=0x0001, Cin=1, op=000 -> rsp_result=0x0004, rsp_cout=0. rsp_valid rises 2 edges after accept.
- Carry out: A=0xFFFF, B=0x0001, Cin=0, op=000 -> rsp_result=0x0000, rsp_cout=1. With ALU_FLAGS_EN: rsp_zero=1, rsp_neg=0.
- Accumulator chain, rsp_ready=1:
  - add 0x0001+0x0001 -> 0x0002
  - use_acc add B=0x0003 -> 0x0005
  - use_acc op=100 -> 0x000A
  - Results arrive every 2 cycles.
- Backpressure: hold rsp_ready=0 and offer 6 commands. Required: exactly 5 accepted (1 in RESP, 4 queued), cmd_ready low thereafter, rsp_* stable throughout. Release rsp_ready: all 5 results drain in order.
- Simultaneous push/pop: with the FIFO at 2 entries, push while RESP completes its handshake -> occupancy stays 2 and ordering is preserved.
- Reset mid-op: assert rst while in EXEC with 3 queued -> the next cycle shows rsp_valid=0, cmd_ready=1, busy=0, alu_* = 0. A subsequent use_acc add B=0x0007 returns 0x0007.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue unit:
//   - ALU control codes (must match ALU_16bit's Control decoding)
//   - issue FSM state encoding
//   - command word layout helpers
// The command word pushed into the FIFO is packed as
//   {use_acc, op[2:0], cin, b[WIDTH-1:0], a[WIDTH-1:0]}
// so it is CMD_CTRL_BITS + 2*WIDTH bits wide.
// Optional feature macro used by the unit: ALU_FLAGS_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // use_acc (1) + op (3) + cin (1)
    localparam int CMD_CTRL_BITS = 5;

    function automatic int cmd_width(input int width);
        return 2 * width + CMD_CTRL_BITS;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO holding packed ALU command words.
// Read data is the current head (show-ahead), valid whenever empty is low.
// Push is ignored when full, pop is ignored when empty. Pointers wrap modulo
// DEPTH (power of two), occupancy counter is log2(DEPTH)+1 bits.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write strobe and data
//   pop            remove head
//   rdata          head entry
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Push and pop on the same edge leave occupancy unchanged.
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Command stage in front of the combinational 16-bit ALU. Commands are queued
// in a FIFO, issued one at a time on registered alu_* lines, the ALU output is
// captured one cycle later and returned on the response port. An accumulator
// holds the last captured result so a command can take operand A from it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. A source keeps valid and its payload stable until the transfer; ready
// may change freely and does not depend on valid.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_cin       operands / carry-in
//   cmd_op, cmd_use_acc         ALU control code, take A from accumulator
//   alu_a, alu_b, alu_cin,      registered operands to the ALU, stable from one
//   alu_ctrl                    pop to the next
//   alu_result, alu_cout        combinational ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_cout        captured ALU outputs
//   busy                        FIFO non-empty or FSM not idle
//   rsp_zero, rsp_neg           (only with ALU_FLAGS_EN) flags of rsp_result
//   dbg_state                   current FSM state, for observation only
//
// Build option: define ALU_FLAGS_EN to add the rsp_zero / rsp_neg outputs.
// -----------------------------------------------------------------------------
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             busy,
`ifdef ALU_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_neg,
`endif
    output state_t           dbg_state
);

    localparam int CMD_W = cmd_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`ifdef ALU_FLAGS_EN
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_neg_q, rsp_neg_d;
`endif

    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_cin;
    logic [2:0]       head_op;
    logic             head_use_acc;

    // cmd_ready depends on occupancy only, so a pop on the same edge never
    // opens a slot at full.
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_use_acc, cmd_op, cmd_cin, cmd_b, cmd_a};

    assign head_a       = fifo_rdata[WIDTH-1:0];
    assign head_b       = fifo_rdata[2*WIDTH-1:WIDTH];
    assign head_cin     = fifo_rdata[2*WIDTH];
    assign head_op      = fifo_rdata[2*WIDTH+3:2*WIDTH+1];
    assign head_use_acc = fifo_rdata[2*WIDTH+4];

    alu_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        acc_d        = acc_q;
        fifo_pop     = 1'b0;
`ifdef ALU_FLAGS_EN
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // alu_* were registered at the pop edge, so the ALU output
                // has had a full cycle to settle.
                rsp_result_d = alu_result;
                rsp_cout_d   = alu_cout;
                acc_d        = alu_result;
                rsp_valid_d  = 1'b1;
`ifdef ALU_FLAGS_EN
                rsp_zero_d   = (alu_result == '0);
                rsp_neg_d    = alu_result[WIDTH-1];
`endif
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Pop straight into EXEC to sustain one result per 2 cycles.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_pop) begin
            // acc_q already holds the previous capture here, which makes
            // back-to-back chaining stall-free.
            alu_a_d    = head_use_acc ? acc_q : head_a;
            alu_b_d    = head_b;
            alu_cin_d  = head_cin;
            alu_ctrl_d = head_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            acc_q        <= '0;
`ifdef ALU_FLAGS_EN
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            acc_q        <= acc_d;
`ifdef ALU_FLAGS_EN
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
`endif
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);
    assign dbg_state  = state_q;
`ifdef ALU_FLAGS_EN
    assign rsp_zero   = rsp_zero_q;
    assign rsp_neg    = rsp_neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
`timescale 1ns/1ps
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT signals ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic [2:0]       cmd_op;
    logic             cmd_use_acc;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic             rsp_zero;
    logic             rsp_neg;
`endif
    state_t           dbg_state;

    always #5 clk = ~clk;

    alu_issue_unit #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .cmd_op      (cmd_op),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_cout    (rsp_cout),
        .busy        (busy),
`ifdef ALU_FLAGS_EN
        .rsp_zero    (rsp_zero),
        .rsp_neg     (rsp_neg),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- ALU behavioural model ({cout, result}) ----------------
    function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin,
                                               input logic [2:0] op);
        logic [WIDTH:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            OP_SUB:  r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            OP_OR:   r = {1'b0, a | b};
            OP_AND:  r = {1'b0, a & b};
            OP_SHL:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_ROL:  r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
            default: r = {a[0], a[0], a[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    always_comb {alu_cout, alu_result} = alu_ref(alu_a, alu_b, alu_cin, alu_ctrl);

    // ---------------- scoreboard ----------------
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   mon_e;
    logic [WIDTH:0]   last_rsp;
    logic [WIDTH-1:0] rsp_log[$];
    int               hs_cycles[$];
    logic [WIDTH-1:0] acc_m;
    int               errors = 0;
    int               checks = 0;
    int               cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: a transfer is due at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            hs_cycles.push_back(cycle);
            rsp_log.push_back(rsp_result);
            last_rsp = {rsp_cout, rsp_result};
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(mon_e[WIDTH-1:0]));
                chk("rsp_cout", 32'(rsp_cout), 32'(mon_e[WIDTH]));
`ifdef ALU_FLAGS_EN
                chk("rsp_zero", 32'(rsp_zero), 32'(mon_e[WIDTH-1:0] == '0));
                chk("rsp_neg", 32'(rsp_neg), 32'(mon_e[WIDTH-1]));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [2:0] op, input logic use_acc,
                        input int budget, output bit accepted);
        logic [WIDTH:0] r;
        cmd_a       = a;
        cmd_b       = b;
        cmd_cin     = cin;
        cmd_op      = op;
        cmd_use_acc = use_acc;
        cmd_valid   = 1'b1;
        accepted    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                r = alu_ref(use_acc ? acc_m : a, b, cin, op);
                exp_q.push_back(r);
                acc_m    = r[WIDTH-1:0];
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && busy === 1'b0) break;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    bit               ok;
    int               n_acc;
    logic [WIDTH-1:0] hold_res;
    logic             hold_c;

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_cin     = 1'b0;
        cmd_op      = '0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;
        acc_m       = '0;
        last_rsp    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_cin", 32'(alu_cin), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // single add with latency: accept at E0, pop at E1, valid after E2
        rsp_ready = 1'b1;
        send(16'h0002, 16'h0001, 1'b1, OP_ADD, 1'b0, 10, ok);
        chk("add_accept", 32'(ok), 32'd1);
        chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_e1_state", 32'(dbg_state), 32'(ST_EXEC));
        chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
        chk("lat_e1_alu_a", 32'(alu_a), 32'h0002);
        chk("lat_e1_alu_b", 32'(alu_b), 32'h0001);
        chk("lat_e1_alu_cin", 32'(alu_cin), 32'd1);
        @(posedge clk); #1;
        chk("lat_e2_valid", 32'(rsp_valid), 32'd1);
        chk("lat_e2_result", 32'(rsp_result), 32'h0004);
        wait_drain(20);
        chk("add_last", 32'(last_rsp), 32'h00004);

        // carry out
        send(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 10, ok);
        wait_drain(20);
        chk("carry_last", 32'(last_rsp), 32'h10000);
`ifdef ALU_FLAGS_EN
        chk("carry_zero", 32'(rsp_zero), 32'd1);
        chk("carry_neg", 32'(rsp_neg), 32'd0);
`endif

        // accumulator chain, one result every 2 cycles
        hs_cycles.delete();
        rsp_log.delete();
        send(16'h0001, 16'h0001, 1'b0, OP_ADD, 1'b0, 10, ok);
        send(16'hBEEF, 16'h0003, 1'b0, OP_ADD, 1'b1, 10, ok);
        send(16'hBEEF, 16'h0000, 1'b0, OP_SHL, 1'b1, 10, ok);
        wait_drain(30);
        chk("chain_count", 32'(rsp_log.size()), 32'd3);
        if (rsp_log.size() == 3 && hs_cycles.size() == 3) begin
            chk("chain_r0", 32'(rsp_log[0]), 32'h0002);
            chk("chain_r1", 32'(rsp_log[1]), 32'h0005);
            chk("chain_r2", 32'(rsp_log[2]), 32'h000A);
            chk("chain_gap01", 32'(hs_cycles[1] - hs_cycles[0]), 32'd2);
            chk("chain_gap12", 32'(hs_cycles[2] - hs_cycles[1]), 32'd2);
        end

        // backpressure: 6 offered, 5 accepted
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 4, ok);
            if (ok) n_acc++;
        end
        chk("bp_accepted", 32'(n_acc), 32'd5);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_state", 32'(dbg_state), 32'(ST_RESP));
        hold_res = rsp_result;
        hold_c   = rsp_cout;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_result", 32'(rsp_result), 32'(hold_res));
            chk("bp_hold_cout", 32'(rsp_cout), 32'(hold_c));
        end
        chk("bp_ready_still_low", 32'(cmd_ready), 32'd0);
        rsp_log.delete();
        rsp_ready = 1'b1;
        wait_drain(60);
        chk("bp_drained", 32'(rsp_log.size()), 32'd5);

        // simultaneous push and pop at occupancy 2
        rsp_ready = 1'b0;
        rsp_log.delete();
        send(16'h0010, 16'h0001, 1'b0, OP_ADD, 1'b0, 10, ok);
        send(16'h0020, 16'h0002, 1'b0, OP_ADD, 1'b0, 10, ok);
        send(16'h0030, 16'h0003, 1'b0, OP_ADD, 1'b0, 10, ok);
        @(posedge clk); #1;
        chk("sim_pre_state", 32'(dbg_state), 32'(ST_RESP));
        chk("sim_pre_count", 32'(dut.u_fifo.count_q), 32'd2);
        cmd_a       = 16'h0040;
        cmd_b       = 16'h0004;
        cmd_cin     = 1'b0;
        cmd_op      = OP_ADD;
        cmd_use_acc = 1'b0;
        cmd_valid   = 1'b1;
        rsp_ready   = 1'b1;
        @(negedge clk);
        chk("sim_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.push_back(alu_ref(16'h0040, 16'h0004, 1'b0, OP_ADD));
        acc_m = 16'h0044;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("sim_post_count", 32'(dut.u_fifo.count_q), 32'd2);
        chk("sim_post_state", 32'(dbg_state), 32'(ST_EXEC));
        wait_drain(30);
        chk("sim_count", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() == 4) begin
            chk("sim_r0", 32'(rsp_log[0]), 32'h0011);
            chk("sim_r1", 32'(rsp_log[1]), 32'h0022);
            chk("sim_r2", 32'(rsp_log[2]), 32'h0033);
            chk("sim_r3", 32'(rsp_log[3]), 32'h0044);
        end

        // reset while in EXEC with 3 queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                 1'b0, OP_ADD, 1'b0, 10, ok);
        end
        chk("rm_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rm_state", 32'(dbg_state), 32'(ST_EXEC));
        chk("rm_count", 32'(dut.u_fifo.count_q), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_m = '0;
        chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_alu_a", 32'(alu_a), 32'd0);
        chk("rm_alu_b", 32'(alu_b), 32'd0);
        chk("rm_alu_cin", 32'(alu_cin), 32'd0);
        chk("rm_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rm_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        rsp_ready = 1'b1;
        send(16'h1234, 16'h0007, 1'b0, OP_ADD, 1'b1, 10, ok);
        wait_drain(20);
        chk("rm_acc_add", 32'(last_rsp), 32'h00007);

        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
